note_detector: RTL and testbench
================================

# note_detector

Receive-side counterpart to the tone generator: measures the period of an incoming square-wave note signal on the 50 MHz system clock and decodes it to a note code (A4, B4, or none). Sits between the board audio/test input pin and the game logic. A note is reported only after it has been stable for several consecutive periods, and silence is detected by timeout.

## Interface
Parameters:
- TOL, 1024: allowed deviation in clock cycles between a measured period and the nominal period.
- LOCK_COUNT, 3: number of consecutive matching periods required to lock, range 1–7.
- MAX_PERIOD, 200000: number of cycles without a rising edge after which the input is declared silent.

Ports:
- externalClock, input, 1: 50 MHz system clock.
- reset, input, 1: asynchronous, active-high reset.
- music_in, input, 1: asynchronous square-wave input.
- note, output, 2: decoded note. 0 = none, 1 = A4, 2 = B4, 3 reserved.
- note_valid, output, 1: high while locked.
- note_change, output, 1: one-cycle pulse whenever `note` or `note_valid` changes.
- period, output, 18: last measured period in cycles.

## Operation
- music_in passes through a 2-FF synchronizer. A rising-edge strobe `rise` is generated from the synchronized signal.
- An 18-bit period counter increments every cycle and saturates at MAX_PERIOD.
  - On `rise`, the count is latched into `period`, then the counter reloads to 1.
- Classification on each `rise`:
  - A4 if |count − 113636| ≤ TOL.
  - B4 if |count − 101238| ≤ TOL.
  - Otherwise none.
  - Comparisons use unsigned 19-bit arithmetic with no wrap.
- A 3-bit match counter tracks consecutive periods that classify to the same note.
- States:
  - IDLE: waiting for the first `rise`. On `rise`, go to MEASURE. The counter starts, and no classification is made for this edge.
  - MEASURE: on `rise`, classify.
    - A class equal to the previous class increments the match counter.
    - A different class or none sets the match counter to 1 (0 for none).
    - When the match counter reaches LOCK_COUNT with class ≠ none, go to LOCKED: set `note` to the class, set `note_valid` to 1, pulse `note_change`.
  - LOCKED: on `rise`, classify.
    - Same class: stay in LOCKED.
    - Different class or none: go to MEASURE, clear `note` and `note_valid`, pulse `note_change`, set the match counter as in MEASURE.
  - Any state: when the counter reaches MAX_PERIOD, go to IDLE, clear `note` and `note_valid`, clear the match counter. Pulse `note_change` only if `note_valid` was 1.
- Simultaneous `rise` and timeout in the same cycle: `rise` wins and the timeout is ignored.
- Reset values: `note` = 0, `note_valid` = 0, `note_change` = 0, `period` = 0, state = IDLE, all counters = 0.
- Reset mid-operation immediately returns every register to its reset value. The first edge after reset is treated as an IDLE edge.

## Timing
- `rise` is asserted 3 cycles after the music_in transition, ±1 cycle of synchronizer uncertainty.
- `period`, `note`, `note_valid` and `note_change` are all registered and update in the cycle after `rise`.
- Time to lock: LOCK_COUNT full periods after the first edge, plus 4 cycles.
- Timeout response occurs MAX_PERIOD cycles after the last `rise`, plus 1 cycle.
- `note_change` is exactly one cycle wide and can never be asserted in two consecutive cycles.

## Configuration
- NOTE_DETECT_GLITCH_FILTER_EN:
  - Defined: a 4-cycle stability filter sits after the synchronizer. The filtered level changes only when the synchronized input has held a new value for 4 consecutive cycles. This adds 4 cycles to `rise` latency.
  - Undefined: no filter. Pulses of 1–3 cycles produce spurious edges, which classify as none.

## Structure
- Shared package `note_pkg` holds:
  - the note code constants NOTE_NONE, NOTE_A4, NOTE_B4;
  - the nominal period constants PERIOD_A4 = 113636 and PERIOD_B4 = 101238;
  - the state enum IDLE/MEASURE/LOCKED;
  - the counter width constant 18.
  - The tone generator adopts the same constants.
- Sub-module `input_conditioner` contains the synchronizer, the optional glitch filter, and the edge detector, and outputs `rise`. All other logic lives in the top-level module.

## Test plan
- A4 square wave with period 113636 cycles: `note` = 1 and `note_valid` = 1 after the 4th rising edge, plus 1 cycle. `period` = 113636 ±1. Exactly one `note_change` pulse.
- B4 with period 101238 cycles, then switched to A4 mid-stream:
  - `note` = 2 after the lock.
  - At the first A4-length period, `note_valid` drops with one `note_change` pulse.
  - Relock to 1 occurs 3 periods later, with one more pulse.
- Off-tone input with period 107000 cycles (outside both windows) for 10 periods: `note_valid` stays 0 and `note_change` never pulses.
- Input stuck low after an A4 lock: `note_valid` falls exactly 200001 cycles after the last `rise`, state returns to IDLE, and one pulse is issued.
- Reset asserted mid-lock for 1 cycle: all outputs go to 0 at once. After release, lock requires 4 fresh edges.
- A 2-cycle glitch injected into an A4 lock:
  - With NOTE_DETECT_GLITCH_FILTER_EN defined: the lock holds.
  - Without it: `note_valid` drops and later relocks.

Source files
------------

// File: rtl/note_pkg.sv
// Shared constants for the note tone generator and note detector.
// Note codes, nominal periods at 50 MHz, detector state encoding and a tolerance helper.
package note_pkg;

    localparam int unsigned CNT_W = 18;

    localparam logic [1:0] NOTE_NONE = 2'd0;
    localparam logic [1:0] NOTE_A4   = 2'd1;
    localparam logic [1:0] NOTE_B4   = 2'd2;

    localparam int unsigned PERIOD_A4 = 113636;
    localparam int unsigned PERIOD_B4 = 101238;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED
    } state_e;

    // One extra bit of headroom so the absolute difference never wraps.
    function automatic logic within_tol(input logic [CNT_W-1:0] cnt,
                                        input logic [CNT_W:0]   nom,
                                        input logic [CNT_W:0]   tol);
        logic [CNT_W:0] c;
        logic [CNT_W:0] diff;
        c    = {1'b0, cnt};
        diff = (c >= nom) ? (c - nom) : (nom - c);
        return (diff <= tol);
    endfunction

endpackage

// File: rtl/input_conditioner.sv
// Synchronises the raw note input and produces a one-cycle rising-edge strobe.
// Build option: NOTE_DETECT_GLITCH_FILTER_EN adds a 4-cycle stability filter after the synchronizer.
module input_conditioner (
    input  logic clk_i,
    input  logic rst_i,
    input  logic music_i,
    output logic rise_o
);

    logic [1:0] sync_q;
    logic       level;
    logic       prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], music_i};
        end
    end

`ifdef NOTE_DETECT_GLITCH_FILTER_EN
    logic       filt_q;
    logic       filt_d;
    logic [1:0] stable_q;
    logic [1:0] stable_d;

    // Flip only after the synchronized level has disagreed for four cycles in a row.
    always_comb begin
        filt_d   = filt_q;
        stable_d = 2'd0;
        if (sync_q[1] != filt_q) begin
            if (stable_q == 2'd3) begin
                filt_d = sync_q[1];
            end else begin
                stable_d = stable_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filt_q   <= 1'b0;
            stable_q <= 2'd0;
        end else begin
            filt_q   <= filt_d;
            stable_q <= stable_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[1];
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign rise_o = level & ~prev_q;

endmodule

// File: rtl/note_detector.sv
// Measures the period of a square-wave note input and decodes it to A4, B4 or none.
// Build option: NOTE_DETECT_GLITCH_FILTER_EN enables the input glitch filter.
module note_detector
    import note_pkg::*;
#(
    parameter int unsigned TOL        = 1024,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned MAX_PERIOD = 200000,
    parameter int unsigned NOM_A4     = PERIOD_A4,
    parameter int unsigned NOM_B4     = PERIOD_B4
) (
    input  logic        externalClock,
    input  logic        reset,
    input  logic        music_in,
    output logic [1:0]  note,
    output logic        note_valid,
    output logic        note_change,
    output logic [17:0] period
);

    localparam logic [CNT_W-1:0] MaxCnt  = MAX_PERIOD[CNT_W-1:0];
    localparam logic [CNT_W:0]   NomA4W  = NOM_A4[CNT_W:0];
    localparam logic [CNT_W:0]   NomB4W  = NOM_B4[CNT_W:0];
    localparam logic [CNT_W:0]   TolW    = TOL[CNT_W:0];
    localparam logic [2:0]       LockCnt = LOCK_COUNT[2:0];

    logic rise;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [2:0]       match_q, match_d;
    logic [1:0]       class_q, class_d;
    logic [1:0]       note_q, note_d;
    logic             valid_q, valid_d;
    logic             change_q, change_d;

    logic             timeout;
    logic [1:0]       cls;
    logic [2:0]       match_next;

    input_conditioner u_cond (
        .clk_i   (externalClock),
        .rst_i   (reset),
        .music_i (music_in),
        .rise_o  (rise)
    );

    assign timeout = (cnt_q == MaxCnt);

    always_comb begin
        if (within_tol(cnt_q, NomA4W, TolW)) begin
            cls = NOTE_A4;
        end else if (within_tol(cnt_q, NomB4W, TolW)) begin
            cls = NOTE_B4;
        end else begin
            cls = NOTE_NONE;
        end
    end

    always_comb begin
        if (cls == NOTE_NONE) begin
            match_next = 3'd0;
        end else if (cls == class_q) begin
            match_next = (match_q == 3'd7) ? match_q : (match_q + 3'd1);
        end else begin
            match_next = 3'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = timeout ? cnt_q : (cnt_q + 18'd1);
        period_d = period_q;
        match_d  = match_q;
        class_d  = class_q;
        note_d   = note_q;
        valid_d  = valid_q;

        // A rising edge takes priority over a coincident timeout.
        if (rise) begin
            cnt_d    = 18'd1;
            period_d = cnt_q;
            unique case (state_q)
                IDLE: begin
                    state_d = MEASURE;
                    class_d = NOTE_NONE;
                    match_d = 3'd0;
                end
                MEASURE: begin
                    class_d = cls;
                    match_d = match_next;
                    if ((cls != NOTE_NONE) && (match_next >= LockCnt)) begin
                        state_d = LOCKED;
                        note_d  = cls;
                        valid_d = 1'b1;
                    end
                end
                LOCKED: begin
                    if (cls != note_q) begin
                        state_d = MEASURE;
                        class_d = cls;
                        match_d = match_next;
                        note_d  = NOTE_NONE;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else if (timeout) begin
            state_d = IDLE;
            class_d = NOTE_NONE;
            match_d = 3'd0;
            note_d  = NOTE_NONE;
            valid_d = 1'b0;
        end

        change_d = (note_d != note_q) || (valid_d != valid_q);
    end

    always_ff @(posedge externalClock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            match_q  <= 3'd0;
            class_q  <= NOTE_NONE;
            note_q   <= NOTE_NONE;
            valid_q  <= 1'b0;
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            match_q  <= match_d;
            class_q  <= class_d;
            note_q   <= note_d;
            valid_q  <= valid_d;
            change_q <= change_d;
        end
    end

    assign note        = note_q;
    assign note_valid  = valid_q;
    assign note_change = change_q;
    assign period      = period_q;

endmodule

// File: tb/tb_note_detector.sv
// Randomised and directed bench for note_detector, checked every cycle against a timing model.
// Runs with scaled nominal periods so whole lock/timeout sequences fit in a short simulation.
`timescale 1ns/1ps
module tb_note_detector;

    localparam int TOL  = 12;
    localparam int LOCK = 3;
    localparam int MAXP = 1000;
    localparam int NA4  = 400;
    localparam int NB4  = 330;
`ifdef NOTE_DETECT_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        music_in = 1'b0;
    logic [1:0]  note;
    logic        note_valid;
    logic        note_change;
    logic [17:0] period;

    note_detector #(
        .TOL        (TOL),
        .LOCK_COUNT (LOCK),
        .MAX_PERIOD (MAXP),
        .NOM_A4     (NA4),
        .NOM_B4     (NB4)
    ) dut (
        .externalClock (clk),
        .reset         (reset),
        .music_in      (music_in),
        .note          (note),
        .note_valid    (note_valid),
        .note_change   (note_change),
        .period        (period)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int changes = 0;
    int last_rise_drive = 0;
    bit cmp_en = 1'b0;

    // Model state: rise times are tracked as posedge indices, classification by plain arithmetic.
    bit [4:0]   mh = '0;
    bit [1:0]   gh = '0;
    int         base = 1;
    int         m_mode = 0;
    int         m_match = 0;
    int         m_period = 0;
    logic [1:0] m_cls = 2'd0;
    logic [1:0] m_note = 2'd0;
    logic       m_valid = 1'b0;
    logic       m_change = 1'b0;

    function automatic logic [1:0] classify(input int cnt);
        int da, db;
        da = (cnt > NA4) ? cnt - NA4 : NA4 - cnt;
        db = (cnt > NB4) ? cnt - NB4 : NB4 - cnt;
        if (da <= TOL) return 2'd1;
        if (db <= TOL) return 2'd2;
        return 2'd0;
    endfunction

    always @(posedge clk) begin
        bit         rise;
        bit         g_new;
        int         count;
        logic [1:0] c;
        logic [1:0] old_note;
        logic       old_valid;
        cyc++;
        if (reset) begin
            mh = '0; gh = '0; base = cyc + 1;
            m_mode = 0; m_match = 0; m_period = 0; m_cls = 2'd0;
            m_note = 2'd0; m_valid = 1'b0; m_change = 1'b0;
        end else begin
            rise = gh[0] && !gh[1];
            if (FILT) g_new = (mh[4:1] == 4'b1111 || mh[4:1] == 4'b0000) ? mh[1] : gh[0];
            else g_new = mh[0];
            gh = {gh[0], g_new};
            mh = {mh[3:0], music_in};
            count = cyc - base;
            if (count > MAXP) count = MAXP;
            old_note = m_note;
            old_valid = m_valid;
            if (rise) begin
                m_period = count;
                base = cyc;
                if (m_mode == 0) begin
                    m_mode = 1; m_cls = 2'd0; m_match = 0;
                end else begin
                    c = classify(count);
                    if (m_mode == 1) begin
                        if (c == 2'd0) m_match = 0;
                        else if (c == m_cls) m_match = (m_match >= 7) ? 7 : m_match + 1;
                        else m_match = 1;
                        m_cls = c;
                        if (c != 2'd0 && m_match >= LOCK) begin
                            m_mode = 2; m_note = c; m_valid = 1'b1;
                        end
                    end else if (c != m_note) begin
                        m_mode = 1; m_match = (c == 2'd0) ? 0 : 1; m_cls = c;
                        m_note = 2'd0; m_valid = 1'b0;
                    end
                end
            end else if (count >= MAXP) begin
                m_mode = 0; m_match = 0; m_cls = 2'd0; m_note = 2'd0; m_valid = 1'b0;
            end
            m_change = (m_note != old_note) || (m_valid != old_valid);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (note !== m_note || note_valid !== m_valid || note_change !== m_change ||
                period !== m_period[17:0]) begin
                errors++;
                $display("FAIL cycle-compare @%0d: note=%0d valid=%0d change=%0d period=%0d, expected %0d %0d %0d %0d",
                         cyc, note, note_valid, note_change, period,
                         m_note, m_valid, m_change, m_period);
            end
            if (note_change === 1'b1) changes++;
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // n square-wave periods of length p; glitch_at >= 0 puts a 2-cycle pulse into the low half.
    task automatic wave(input int p, input int n, input int glitch_at);
        for (int k = 0; k < n; k++) begin
            for (int t = 0; t < p; t++) begin
                @(negedge clk); #1;
                if (t < p / 2) music_in = 1'b1;
                else if (glitch_at >= 0 && t >= p / 2 + glitch_at && t < p / 2 + glitch_at + 2)
                    music_in = 1'b1;
                else music_in = 1'b0;
                if (t == 0) last_rise_drive = cyc;
            end
        end
    endtask

    task automatic silence(input int n);
        repeat (n) begin
            @(negedge clk); #1;
            music_in = 1'b0;
        end
    endtask

    int c0;
    int delta;
    int tbl_p[6];
    int tbl_n[6];

    initial begin
        repeat (3) @(negedge clk);
        #1;
        cmp_en = 1'b1;
        chk("reset_note", int'(note), 0);
        chk("reset_valid", int'(note_valid), 0);
        chk("reset_change", int'(note_change), 0);
        chk("reset_period", int'(period), 0);
        reset = 1'b0;
        silence(20);

        // Clean A4 from idle
        c0 = changes;
        wave(NA4, 6, -1);
        chk("a4_note", int'(note), 1);
        chk("a4_valid", int'(note_valid), 1);
        chk("a4_period", int'(period), NA4);
        chk("a4_pulses", changes - c0, 1);

        // B4 stream, then switch to A4
        c0 = changes;
        wave(NB4, 6, -1);
        chk("b4_note", int'(note), 2);
        chk("b4_pulses", changes - c0, 2);
        c0 = changes;
        wave(NA4, 5, -1);
        chk("b4a4_note", int'(note), 1);
        chk("b4a4_pulses", changes - c0, 2);

        // Silence, then off-tone never locks
        silence(MAXP + 50);
        c0 = changes;
        wave(365, 10, -1);
        chk("off_valid", int'(note_valid), 0);
        chk("off_pulses", changes - c0, 0);
        chk("off_period", int'(period), 365);

        // Stuck low after A4 lock
        wave(NA4, 5, -1);
        c0 = changes;
        for (int i = 0; i < MAXP + 100; i++) begin
            @(negedge clk); #1;
            if (!note_valid) break;
        end
        delta = cyc - last_rise_drive;
        chk("timeout_delay", delta, MAXP + 3 + (FILT ? 4 : 0));
        chk("timeout_pulses", changes - c0, 1);

        // Reset in the middle of a lock
        wave(NA4, 5, -1);
        chk("prereset_valid", int'(note_valid), 1);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        chk("midreset_note", int'(note), 0);
        chk("midreset_valid", int'(note_valid), 0);
        chk("midreset_period", int'(period), 0);
        @(negedge clk); #1;
        reset = 1'b0;
        wave(NA4, 3, -1);
        chk("relock_3_edges", int'(note_valid), 0);
        wave(NA4, 1, -1);
        chk("relock_4_edges", int'(note_valid), 1);

        // Short glitch inside an A4 lock
        wave(NA4, 2, -1);
        c0 = changes;
        wave(NA4, 1, 60);
        wave(NA4, 5, -1);
        chk("glitch_pulses", changes - c0, FILT ? 0 : 2);
        chk("glitch_valid", int'(note_valid), 1);

        // Window boundaries
        tbl_p = '{NA4 - TOL, NA4 + TOL, NA4 + TOL + 1, NB4 - TOL, NB4 - TOL - 1, NB4 + TOL};
        tbl_n = '{1, 1, 0, 2, 0, 2};
        for (int i = 0; i < 6; i++) begin
            wave(tbl_p[i], 4, -1);
            chk("bound_note", int'(note), tbl_n[i]);
            chk("bound_period", int'(period), tbl_p[i]);
        end

        // Random segments
        for (int s = 0; s < 20; s++) begin
            case ($urandom_range(0, 4))
                0: wave($urandom_range(NA4 - TOL - 3, NA4 + TOL + 3), $urandom_range(1, 4), -1);
                1: wave($urandom_range(NB4 - TOL - 3, NB4 + TOL + 3), $urandom_range(1, 4), -1);
                2: wave($urandom_range(20, 1300), $urandom_range(1, 2), -1);
                3: wave(NA4, 1, $urandom_range(5, 150));
                default: silence($urandom_range(50, 1200));
            endcase
        end
        silence(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
